// File: rtl/freq_meter.sv
// freq_meter -- counts rising edges of an asynchronous input over a fixed
// gate window of GATE_CYCLES clock cycles and reports the count.
//
// Parameters:
//   CLOCK_FREQ  - clock frequency in Hz (only sets the default window length)
//   GATE_CYCLES - window length in clock cycles (default: 1 s)
//   COUNT_W     - width of the edge count
//
// Ports:
//   clock    in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   enable   in   1 = run measurement windows back-to-back
//   sig_in   in   asynchronous signal to measure (must stay below CLOCK_FREQ/2)
//   freq_out out  rising-edge count of the last completed window
//   valid    out  one-cycle pulse, aligned with a new freq_out value
//   busy     out  high while a window is open
//   overflow out  count of the last completed window saturated
//                 (only with FREQ_METER_OVF_EN defined)
//
// Build option: FREQ_METER_OVF_EN -- saturate the edge count and provide the
// overflow port. Without it the count wraps modulo 2^COUNT_W.
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | no window open, waiting for enable
// GATE  | window open, counting sig_in rises each cycle

module freq_meter #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int GATE_CYCLES = CLOCK_FREQ,
  parameter int COUNT_W     = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_out,
  output logic               valid,
  output logic               busy
`ifdef FREQ_METER_OVF_EN
  ,
  output logic               overflow
`endif
);

  localparam int GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GC_W-1:0] GATE_LAST = GC_W'(GATE_CYCLES - 1);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_GATE = 1'b1;

  logic               sync1_q, sync2_q, sync3_q;
  logic               rise;
  logic               state_q, state_d;
  logic [GC_W-1:0]    gate_cnt_q, gate_cnt_d;
  logic [COUNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [COUNT_W-1:0] edge_inc;
  logic [COUNT_W-1:0] freq_q, freq_d;
  logic               valid_q, valid_d;
  logic               busy_q;
  logic               terminal;

  // sync1/sync2 resolve metastability; sync3 only delays for edge detection.
  assign rise     = sync2_q & ~sync3_q;
  assign terminal = (gate_cnt_q == GATE_LAST);

`ifdef FREQ_METER_OVF_EN
  logic sat_q, sat_d;
  logic sat_now;
  logic ovf_q, ovf_d;
  logic at_max;

  assign at_max   = &edge_cnt_q;
  assign edge_inc = (rise && !at_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
  // Saturation means a rise was lost, not merely that the count hit max.
  assign sat_now  = sat_q | (rise & at_max);
`else
  assign edge_inc = edge_cnt_q + COUNT_W'(rise);
`endif

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    freq_d     = freq_q;
    valid_d    = 1'b0;
`ifdef FREQ_METER_OVF_EN
    sat_d      = sat_q;
    ovf_d      = ovf_q;
`endif
    if (state_q == S_IDLE) begin
      if (enable) begin
        state_d    = S_GATE;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
`ifdef FREQ_METER_OVF_EN
        sat_d      = 1'b0;
`endif
      end
    end else begin
      if (terminal) begin
        // A rise in the terminal cycle still belongs to this window; the next
        // window starts counting from the following cycle, so nothing is lost.
        freq_d     = edge_inc;
        valid_d    = 1'b1;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
`ifdef FREQ_METER_OVF_EN
        ovf_d      = sat_now;
        sat_d      = 1'b0;
`endif
        if (!enable) state_d = S_IDLE;
      end else if (!enable) begin
        state_d    = S_IDLE;
        gate_cnt_d = '0;
        edge_cnt_d = '0;
`ifdef FREQ_METER_OVF_EN
        sat_d      = 1'b0;
`endif
      end else begin
        gate_cnt_d = gate_cnt_q + 1'b1;
        edge_cnt_d = edge_inc;
`ifdef FREQ_METER_OVF_EN
        sat_d      = sat_now;
`endif
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      state_q    <= S_IDLE;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sig_in;
      sync2_q    <= sync1_q;
      sync3_q    <= sync2_q;
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
      // Registered from the next state so busy tracks state_q exactly.
      busy_q     <= (state_d == S_GATE);
    end
  end

`ifdef FREQ_METER_OVF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`endif

  assign freq_out = freq_q;
  assign valid    = valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_freq_meter.sv
`timescale 1ns/1ps
module tb_freq_meter;

  localparam int GATE = 100;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable  = 1'b0;
  logic       enable2 = 1'b0;
  logic       sig_in  = 1'b0;
  logic [7:0] freq1;
  logic       valid1, busy1;
  logic [3:0] freq2;
  logic       valid2, busy2;
`ifdef FREQ_METER_OVF_EN
  logic       ovf1, ovf2;
`endif

  int period = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int period;
    int n_win;
    int exp_freq;
  } vec_t;

  vec_t vecs[7];

  always #5 clock = ~clock;

  freq_meter #(.CLOCK_FREQ(1000), .GATE_CYCLES(GATE), .COUNT_W(8)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .sig_in   (sig_in),
    .freq_out (freq1),
    .valid    (valid1),
    .busy     (busy1)
`ifdef FREQ_METER_OVF_EN
    ,
    .overflow (ovf1)
`endif
  );

  freq_meter #(.CLOCK_FREQ(1000), .GATE_CYCLES(GATE), .COUNT_W(4)) dut4 (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable2),
    .sig_in   (sig_in),
    .freq_out (freq2),
    .valid    (valid2),
    .busy     (busy2)
`ifdef FREQ_METER_OVF_EN
    ,
    .overflow (ovf2)
`endif
  );

  // Periodic sig_in: high for period/2 cycles, restarts phase on period change.
  initial begin : sig_gen
    int ph;
    int last;
    ph   = 0;
    last = 0;
    forever begin
      @(negedge clock);
      if (period != last) begin
        ph   = 0;
        last = period;
      end
      if (period == 0) sig_in = 1'b0;
      else begin
        sig_in = (ph < period / 2);
        ph     = (ph + 1 >= period) ? 0 : ph + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input bit second, output int lat);
    lat = 0;
    do begin
      @(negedge clock);
      lat++;
    end while (!(second ? valid2 : valid1) && lat < 250);
  endtask

  task automatic run_windows(input int per, input int n, input int exp_f);
    int lat;
    enable = 1'b0;
    period = per;
    repeat (10) @(negedge clock);
    check("idle busy", busy1, 0);
    enable = 1'b1;
    @(negedge clock);
    check("busy after enable", busy1, 1);
    for (int w = 0; w < n; w++) begin
      wait_valid(1'b0, lat);
      check("valid spacing", lat, GATE);
      check("freq_out", freq1, exp_f);
`ifdef FREQ_METER_OVF_EN
      check("overflow 8b", ovf1, 0);
`endif
    end
    enable = 1'b0;
    @(negedge clock);
    check("valid one cycle", valid1, 0);
    check("busy after stop", busy1, 0);
  endtask

  task automatic run_small(input int per, input int exp_f, input int exp_o);
    int lat;
    enable2 = 1'b0;
    period  = per;
    repeat (10) @(negedge clock);
    enable2 = 1'b1;
    wait_valid(1'b1, lat);
    check("4b valid latency", lat, GATE + 1);
    check("4b freq_out", freq2, exp_f);
`ifdef FREQ_METER_OVF_EN
    check("4b overflow", ovf2, exp_o);
`else
    if (exp_o > 1) check("4b unused", 0, 1);
`endif
    enable2 = 1'b0;
    @(negedge clock);
  endtask

  initial begin : main
    int  lat;
    bit  saw;
    vecs[0] = '{period: 10,  n_win: 3, exp_freq: 10};
    vecs[1] = '{period: 5,   n_win: 2, exp_freq: 20};
    vecs[2] = '{period: 20,  n_win: 1, exp_freq: 5};
    vecs[3] = '{period: 4,   n_win: 2, exp_freq: 25};
    vecs[4] = '{period: 100, n_win: 1, exp_freq: 1};
    vecs[5] = '{period: 0,   n_win: 1, exp_freq: 0};
    vecs[6] = '{period: 50,  n_win: 1, exp_freq: 2};

    // Reset held with sig_in toggling and enable high.
    period  = 3;
    enable  = 1'b1;
    enable2 = 1'b1;
    repeat (8) begin
      @(negedge clock);
      check("rst freq", freq1, 0);
      check("rst valid", valid1, 0);
      check("rst busy", busy1, 0);
`ifdef FREQ_METER_OVF_EN
      check("rst ovf", ovf2, 0);
`endif
    end
    enable  = 1'b0;
    enable2 = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_windows(vecs[i].period, vecs[i].n_win, vecs[i].exp_freq);

    // Abort at gate cycle 50 after a completed window of 10.
    run_windows(10, 1, 10);
    repeat (10) @(negedge clock);
    enable = 1'b1;
    repeat (51) @(negedge clock);
    check("abort busy before", busy1, 1);
    enable = 1'b0;
    @(negedge clock);
    check("abort busy", busy1, 0);
    saw = 1'b0;
    repeat (150) begin
      @(negedge clock);
      if (valid1) saw = 1'b1;
    end
    check("abort no valid", saw, 0);
    check("abort freq held", freq1, 10);

    // Narrow counter: saturation vs wrap.
    run_small(10, 10, 0);
`ifdef FREQ_METER_OVF_EN
    run_small(4, 15, 1);
`else
    run_small(4, 9, 0);
`endif
    run_small(10, 10, 0);
`ifdef FREQ_METER_OVF_EN
    run_small(4, 15, 1);
`else
    run_small(4, 9, 0);
`endif

    // Reset pulsed at gate cycle 70.
    period = 10;
    repeat (10) @(negedge clock);
    enable  = 1'b1;
    enable2 = 1'b1;
    repeat (71) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst freq", freq1, 0);
    check("midrst valid", valid1, 0);
    check("midrst busy", busy1, 0);
    check("midrst freq4", freq2, 0);
    check("midrst busy4", busy2, 0);
`ifdef FREQ_METER_OVF_EN
    check("midrst ovf4", ovf2, 0);
`endif
    enable  = 1'b0;
    enable2 = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (valid1 || busy1) saw = 1'b1;
    end
    check("post rst quiet", saw, 0);
    run_windows(10, 1, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 The module SHALL have parameter CLOCK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 The module SHALL have parameter GATE_CYCLES, default CLOCK_FREQ, giving the measurement window length in clock cycles, so the default window is 1 s.
REQ-003 The module SHALL have parameter COUNT_W, default 32, giving the width of the edge count.
REQ-004 The module SHALL have port clock, input, 1 bit, the single system clock; all logic is clocked on its rising edge.
REQ-005 The module SHALL have port reset_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-006 The module SHALL have port enable, input, 1 bit, synchronous to clock; 1 runs measurement windows back-to-back.
REQ-007 The module SHALL have port sig_in, input, 1 bit, the asynchronous signal whose rising edges are counted, for example a divided clock.
REQ-008 The module SHALL have port freq_out, output, COUNT_W bits, the rising-edge count of the last completed window.
REQ-009 The module SHALL have port valid, output, 1 bit, a single-cycle pulse marking a new freq_out value.
REQ-010 The module SHALL have port busy, output, 1 bit, high while a window is open.
REQ-011 The module SHALL have port overflow, output, 1 bit, high when the count of the last completed window saturated; it is present only under the macro in REQ-027.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer and then a third flop; a rise is defined as sync2 & ~sync3.
REQ-013 Supported input frequency SHALL be below CLOCK_FREQ/2; faster inputs are out of spec.
REQ-014 The FSM SHALL have exactly two states: IDLE and GATE.
REQ-015 In IDLE with enable=1, the next cycle SHALL enter GATE with gate_cnt=0 and edge_cnt=0.
REQ-016 In GATE, gate_cnt SHALL increment every cycle, and edge_cnt SHALL increment on every cycle in which a rise occurs.
REQ-017 The terminal cycle SHALL be the cycle in which gate_cnt == GATE_CYCLES-1; a rise in the terminal cycle is included in the count.
REQ-018 On the terminal cycle, freq_out SHALL register edge_cnt plus the current rise; valid SHALL be 1 in the next cycle only, aligned with the new freq_out.
REQ-019 On the terminal cycle with enable=1, gate_cnt and edge_cnt SHALL clear and GATE SHALL continue with no dead cycle and no lost edges.
REQ-020 On the terminal cycle with enable=0, the FSM SHALL go to IDLE.
REQ-021 If enable=0 in any non-terminal GATE cycle, the window SHALL be aborted: the FSM goes to IDLE, counters clear, no valid is issued, and freq_out and overflow are unchanged.
REQ-022 busy SHALL equal (state==GATE) and SHALL be registered.
REQ-023 freq_out SHALL hold its value between valid pulses.
REQ-024 gate_cnt SHALL be sized with $clog2(GATE_CYCLES) bits, minimum 1 bit.

Reset
REQ-025 While reset_n=0, the following SHALL hold immediately, independent of clock: state=IDLE; gate_cnt, edge_cnt and synchronizer flops are 0; freq_out=0, valid=0, busy=0, overflow=0.
REQ-026 Reset asserted mid-window SHALL discard the window, and no valid SHALL be issued after release; measurement resumes when enable is seen high after release.

Configuration
REQ-027 With macro FREQ_METER_OVF_EN defined, edge_cnt SHALL saturate at 2^COUNT_W-1, and overflow SHALL register the saturation status at each terminal cycle, aligned with valid and held until the next completed window.
REQ-028 Without FREQ_METER_OVF_EN, edge_cnt SHALL wrap modulo 2^COUNT_W, and the overflow port and saturation logic SHALL be absent.

Verification
Bench parameters: GATE_CYCLES=100, COUNT_W=8, unless noted otherwise.
REQ-029 Reset: reset_n=0 with sig_in toggling -> freq_out=0, valid=0, busy=0 and overflow=0 throughout reset.
REQ-030 Single window: enable=1, sig_in period 10 cycles -> busy=1 from the next cycle; after 100 gate cycles, one valid pulse with freq_out=10.
REQ-031 Continuous: enable held at 1 for 3 windows, sig_in period 10 -> valid pulses exactly 100 cycles apart, each with freq_out=10, and no edge lost across window boundaries.
REQ-032 Abort: enable dropped at gate cycle 50 with a prior freq_out=10 -> no valid, busy=0 on the next cycle, and freq_out stays 10.
REQ-033 Overflow: COUNT_W=4 and sig_in period 4, giving 25 rises -> with FREQ_METER_OVF_EN, freq_out=15 and overflow=1; without it, freq_out=9.
REQ-034 Reset mid-window: reset_n pulsed low at gate cycle 70 -> outputs are zero immediately, and the first valid after release comes only from a full new window.
